// File: rtl/trace_pkg.sv
// Shared types for the commit-trace checker: trace entry layout, event kinds
// and checker states.
package trace_pkg;

  localparam int TRACE_CYC_W = 32;

  typedef enum logic [1:0] {
    KIND_REG  = 2'd0,
    KIND_HILO = 2'd1,
    KIND_MEM  = 2'd2,
    KIND_RSVD = 2'd3
  } TraceKind_t;

  typedef struct packed {
    logic                   skip;
    TraceKind_t             kind;
    logic [15:0]            addr;
    logic [63:0]            data;
    logic [TRACE_CYC_W-1:0] cycle;
  } TraceEntry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FAIL = 2'd2,
    ST_OVF  = 2'd3
  } CheckState_t;

  // A golden entry with skip set accepts anything; the stamp matters only on request.
  function automatic logic entry_match(input TraceEntry_t got, input TraceEntry_t exp,
                                       input logic use_cyc);
    return exp.skip ||
           ((got.kind == exp.kind) && (got.addr == exp.addr) && (got.data == exp.data) &&
            (!use_cyc || (got.cycle == exp.cycle)));
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular buffer accepting up to LANES entries per cycle (slot 0 first) and
// releasing one per cycle from the head.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DEPTH = 16,
  localparam int PW = $clog2(DEPTH) + 1,
  localparam int CW = $clog2(LANES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic [CW-1:0] i_push_cnt,
  input  TraceEntry_t   i_push_data [LANES],
  input  logic          i_pop,
  output TraceEntry_t   o_head,
  output logic          o_empty,
  output logic [PW-1:0] o_free_slots
);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  TraceEntry_t   r_mem [DEPTH];
  logic [PW-1:0] w_count;
  logic [PW-1:0] w_wr_idx [LANES];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_count      = r_wr_ptr - r_rd_ptr;
  assign o_empty      = (r_wr_ptr == r_rd_ptr);
  assign o_free_slots = PW'(DEPTH) - w_count;
  assign o_head       = r_mem[r_rd_ptr[PW-2:0]];

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_wr_idx[i] = r_wr_ptr + PW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(i_push_cnt);
      if (i_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (CW'(i) < i_push_cnt) r_mem[w_wr_idx[i][PW-2:0]] <= i_push_data[i];
    end
  end

endmodule

// File: rtl/commit_trace_checker.sv
// Captures per-lane retire events, queues them in lane order and checks them
// one per cycle against a golden trace stream.
module commit_trace_checker
  import trace_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DEPTH = 16,
  parameter int CYC_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               start,
  input  logic               check_cyc,
  input  logic [LANES-1:0]   ev_valid,
  input  logic [LANES*2-1:0] ev_kind,
  input  logic [LANES*16-1:0] ev_addr,
  input  logic [LANES*64-1:0] ev_data,
  input  logic               gold_valid,
  output logic               gold_ready,
  input  TraceEntry_t        gold_entry,
  output logic [1:0]         state,
  output logic [31:0]        pass_count,
  output logic               err,
  output TraceEntry_t        err_got,
  output TraceEntry_t        err_exp,
  output logic               ovf
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(LANES + 1);

  CheckState_t  r_state;
  logic [CYC_W-1:0] r_cyc;
  logic         r_check_cyc;
  logic [31:0]  r_pass_count;
  logic         r_err;
  logic         r_ovf;
  TraceEntry_t  r_err_got;
  TraceEntry_t  r_err_exp;

  logic [LANES-1:0] w_keep;
  logic [CW-1:0]    w_keep_cnt;
  TraceEntry_t      w_comp [LANES];
  logic [TRACE_CYC_W-1:0] w_stamp;
  logic             w_active;
  logic             w_empty;
  logic [PW-1:0]    w_free_slots;
  logic [PW:0]      w_room;
  logic             w_ovf_hit;
  logic             w_pop;
  logic             w_match;
  logic [CW-1:0]    w_push_cnt;
  TraceEntry_t      w_head;

  assign w_stamp = TRACE_CYC_W'(r_cyc);

  // Register-zero writes and the reserved kind never reach the queue.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_keep[i] = ev_valid[i] && (ev_kind[2*i +: 2] != 2'd3) &&
                  !((ev_kind[2*i +: 2] == 2'd0) && (ev_addr[16*i +: 16] == 16'd0));
    end
  end

  always_comb begin
    w_keep_cnt = '0;
    for (int i = 0; i < LANES; i++) w_comp[i] = '0;
    for (int i = 0; i < LANES; i++) begin
      if (w_keep[i]) begin
        w_comp[w_keep_cnt] = '{skip:  1'b0,
                               kind:  TraceKind_t'(ev_kind[2*i +: 2]),
                               addr:  ev_addr[16*i +: 16],
                               data:  ev_data[64*i +: 64],
                               cycle: w_stamp};
        w_keep_cnt = w_keep_cnt + CW'(1);
      end
    end
  end

  // The same-cycle pop frees its slot before the push is judged.
  assign w_active   = (r_state == ST_RUN) && !clear;
  assign w_pop      = w_active && !w_empty && gold_valid;
  assign w_room     = (PW+1)'(w_free_slots) + (PW+1)'(w_pop);
  assign w_ovf_hit  = w_active && ((PW+1)'(w_keep_cnt) > w_room);
  assign w_push_cnt = (w_active && !w_ovf_hit) ? w_keep_cnt : '0;
  assign w_match    = entry_match(w_head, gold_entry, r_check_cyc);

  trace_fifo #(
    .LANES (LANES),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_flush      (clear),
    .i_push_cnt   (w_push_cnt),
    .i_push_data  (w_comp),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_empty      (w_empty),
    .o_free_slots (w_free_slots)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cyc        <= '0;
      r_check_cyc  <= 1'b0;
      r_pass_count <= '0;
      r_err        <= 1'b0;
      r_ovf        <= 1'b0;
      r_err_got    <= '0;
      r_err_exp    <= '0;
    end else if (clear) begin
      r_state      <= ST_IDLE;
      r_cyc        <= '0;
      r_check_cyc  <= 1'b0;
      r_pass_count <= '0;
      r_err        <= 1'b0;
      r_ovf        <= 1'b0;
      r_err_got    <= '0;
      r_err_exp    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_RUN;
            r_cyc       <= '0;
            r_check_cyc <= check_cyc;
          end
        end
        ST_RUN: begin
          r_cyc <= r_cyc + CYC_W'(1);
          if (w_ovf_hit) begin
            r_ovf   <= 1'b1;
            r_state <= ST_OVF;
          end
          // A mismatch in the same cycle outranks the overflow for the state.
          if (w_pop) begin
            if (w_match) begin
              r_pass_count <= r_pass_count + 32'd1;
            end else begin
              r_err     <= 1'b1;
              r_err_got <= w_head;
              r_err_exp <= gold_entry;
              r_state   <= ST_FAIL;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign gold_ready = w_pop;
  assign state      = r_state;
  assign pass_count = r_pass_count;
  assign err        = r_err;
  assign err_got    = r_err_got;
  assign err_exp    = r_err_exp;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_commit_trace_checker.sv
// Directed bench for commit_trace_checker: a DEPTH=16 instance and a DEPTH=4
// instance share all stimulus.
module tb_commit_trace_checker;
  import trace_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         clear;
  logic         start;
  logic         check_cyc;
  logic [1:0]   ev_valid;
  logic [3:0]   ev_kind;
  logic [31:0]  ev_addr;
  logic [127:0] ev_data;
  logic         gold_valid;
  TraceEntry_t  gold_entry;

  logic         gold_ready_a, gold_ready_b;
  logic [1:0]   state_a, state_b;
  logic [31:0]  pass_count_a, pass_count_b;
  logic         err_a, err_b;
  TraceEntry_t  err_got_a, err_got_b, err_exp_a, err_exp_b;
  logic         ovf_a, ovf_b;

  int n_checks = 0;
  int n_fail   = 0;

  commit_trace_checker #(.LANES(2), .DEPTH(16), .CYC_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .start(start), .check_cyc(check_cyc),
    .ev_valid(ev_valid), .ev_kind(ev_kind), .ev_addr(ev_addr), .ev_data(ev_data),
    .gold_valid(gold_valid), .gold_ready(gold_ready_a), .gold_entry(gold_entry),
    .state(state_a), .pass_count(pass_count_a), .err(err_a),
    .err_got(err_got_a), .err_exp(err_exp_a), .ovf(ovf_a)
  );

  commit_trace_checker #(.LANES(2), .DEPTH(4), .CYC_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .start(start), .check_cyc(check_cyc),
    .ev_valid(ev_valid), .ev_kind(ev_kind), .ev_addr(ev_addr), .ev_data(ev_data),
    .gold_valid(gold_valid), .gold_ready(gold_ready_b), .gold_entry(gold_entry),
    .state(state_b), .pass_count(pass_count_b), .err(err_b),
    .err_got(err_got_b), .err_exp(err_exp_b), .ovf(ovf_b)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_lanes();
    ev_valid = '0;
    ev_kind  = '0;
    ev_addr  = '0;
    ev_data  = '0;
  endtask

  task automatic set_lane(input int ln, input logic [1:0] k, input logic [15:0] a,
                          input logic [63:0] d);
    ev_valid[ln]         = 1'b1;
    ev_kind[2*ln +: 2]   = k;
    ev_addr[16*ln +: 16] = a;
    ev_data[64*ln +: 64] = d;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic do_start(input logic cc);
    start     = 1'b1;
    check_cyc = cc;
    step();
    start     = 1'b0;
    check_cyc = 1'b0;
  endtask

  function automatic TraceEntry_t mk(input logic skip, input logic [1:0] kind,
                                     input logic [15:0] addr, input logic [63:0] data,
                                     input logic [31:0] cyc);
    TraceEntry_t e;
    e.skip  = skip;
    e.kind  = TraceKind_t'(kind);
    e.addr  = addr;
    e.data  = data;
    e.cycle = cyc;
    return e;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++; if (state_a !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", state_a); end
    n_checks++; if (pass_count_a !== 32'd0) begin n_fail++; $display("FAIL reset_pass got %0d exp 0", pass_count_a); end
    n_checks++; if ({err_a, ovf_a, gold_ready_a} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {err_a, ovf_a, gold_ready_a}); end
    n_checks++; if ((err_got_a !== '0) || (err_exp_a !== '0)) begin n_fail++; $display("FAIL reset_records got %0h/%0h exp 0", err_got_a, err_exp_a); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_checks++; if (state_b !== 2'd0) begin n_fail++; $display("FAIL reset_idle_b got %0d exp 0", state_b); end
  endtask

  task automatic test_dual_reg();
    do_clear();
    do_start(1'b1);
    n_checks++; if (state_a !== 2'd1) begin n_fail++; $display("FAIL dual_run got %0d exp 1", state_a); end
    repeat (5) step();
    set_lane(0, 2'd0, 16'd3, 64'h11);
    set_lane(1, 2'd0, 16'd4, 64'h22);
    step();
    clear_lanes();
    gold_valid = 1'b1;
    gold_entry = mk(1'b0, 2'd0, 16'd3, 64'h11, 32'd5);
    #1;
    n_checks++; if (gold_ready_a !== 1'b1) begin n_fail++; $display("FAIL dual_ready0 got %b exp 1", gold_ready_a); end
    step();
    n_checks++; if (pass_count_a !== 32'd1) begin n_fail++; $display("FAIL dual_pass1 got %0d exp 1", pass_count_a); end
    gold_entry = mk(1'b0, 2'd0, 16'd4, 64'h22, 32'd5);
    #1;
    n_checks++; if (gold_ready_a !== 1'b1) begin n_fail++; $display("FAIL dual_ready1 got %b exp 1", gold_ready_a); end
    step();
    gold_valid = 1'b0;
    n_checks++; if (pass_count_a !== 32'd2) begin n_fail++; $display("FAIL dual_pass2 got %0d exp 2", pass_count_a); end
    n_checks++; if ((err_a !== 1'b0) || (state_a !== 2'd1)) begin n_fail++; $display("FAIL dual_err got err=%b state=%0d exp err=0 state=1", err_a, state_a); end
  endtask

  task automatic test_filter();
    do_clear();
    do_start(1'b0);
    set_lane(0, 2'd0, 16'd0, 64'h99);
    set_lane(1, 2'd2, 16'h0010, 64'hdeadbeef);
    gold_valid = 1'b1;
    gold_entry = mk(1'b0, 2'd2, 16'h0010, 64'hdeadbeef, 32'd0);
    #1;
    n_checks++; if (gold_ready_a !== 1'b0) begin n_fail++; $display("FAIL no_fallthrough got %b exp 0", gold_ready_a); end
    step();
    clear_lanes();
    #1;
    n_checks++; if (gold_ready_a !== 1'b1) begin n_fail++; $display("FAIL filter_ready got %b exp 1", gold_ready_a); end
    step();
    n_checks++; if (pass_count_a !== 32'd1) begin n_fail++; $display("FAIL filter_pass got %0d exp 1", pass_count_a); end
    n_checks++; if (gold_ready_a !== 1'b0) begin n_fail++; $display("FAIL filter_reg0_dropped got %b exp 0", gold_ready_a); end
    set_lane(0, 2'd3, 16'd5, 64'h5);
    step();
    clear_lanes();
    n_checks++; if (gold_ready_a !== 1'b0) begin n_fail++; $display("FAIL filter_kind3_dropped got %b exp 0", gold_ready_a); end
    step();
    gold_valid = 1'b0;
    n_checks++; if ((pass_count_a !== 32'd1) || (err_a !== 1'b0)) begin n_fail++; $display("FAIL filter_final got pass=%0d err=%b exp pass=1 err=0", pass_count_a, err_a); end
  endtask

  task automatic test_cycle_mismatch();
    do_clear();
    do_start(1'b1);
    repeat (2) step();
    set_lane(0, 2'd0, 16'd5, 64'h55);
    step();
    clear_lanes();
    gold_valid = 1'b1;
    gold_entry = mk(1'b0, 2'd0, 16'd5, 64'h55, 32'd1);
    #1;
    n_checks++; if ((gold_ready_a !== 1'b1) || (state_a !== 2'd1)) begin n_fail++; $display("FAIL cyc_compare got ready=%b state=%0d exp ready=1 state=1", gold_ready_a, state_a); end
    step();
    n_checks++; if ((state_a !== 2'd2) || (err_a !== 1'b1)) begin n_fail++; $display("FAIL cyc_fail got state=%0d err=%b exp state=2 err=1", state_a, err_a); end
    n_checks++; if (err_got_a !== mk(1'b0, 2'd0, 16'd5, 64'h55, 32'd2)) begin n_fail++; $display("FAIL cyc_err_got got %0h exp stamp 2", err_got_a); end
    n_checks++; if (err_exp_a.cycle !== 32'd1) begin n_fail++; $display("FAIL cyc_err_exp got %0d exp 1", err_exp_a.cycle); end
    n_checks++; if (pass_count_a !== 32'd0) begin n_fail++; $display("FAIL cyc_pass got %0d exp 0", pass_count_a); end
    set_lane(0, 2'd0, 16'd6, 64'h66);
    step();
    clear_lanes();
    n_checks++; if ((gold_ready_a !== 1'b0) || (state_a !== 2'd2)) begin n_fail++; $display("FAIL cyc_terminal got ready=%b state=%0d exp ready=0 state=2", gold_ready_a, state_a); end
    gold_valid = 1'b0;
  endtask

  task automatic test_skip();
    do_clear();
    do_start(1'b0);
    set_lane(0, 2'd1, 16'd0, {32'h1, 32'h2});
    set_lane(1, 2'd0, 16'd7, 64'h5);
    step();
    clear_lanes();
    gold_valid = 1'b1;
    gold_entry = mk(1'b1, 2'd0, 16'd0, 64'h0, 32'd0);
    step();
    n_checks++; if (pass_count_a !== 32'd1) begin n_fail++; $display("FAIL skip_pass got %0d exp 1", pass_count_a); end
    gold_entry = mk(1'b0, 2'd0, 16'd7, 64'h6, 32'd0);
    step();
    n_checks++; if ((err_a !== 1'b1) || (state_a !== 2'd2)) begin n_fail++; $display("FAIL skip_data_err got err=%b state=%0d exp err=1 state=2", err_a, state_a); end
    n_checks++; if ((err_got_a.data !== 64'h5) || (err_exp_a.data !== 64'h6)) begin n_fail++; $display("FAIL skip_records got %0h/%0h exp 5/6", err_got_a.data, err_exp_a.data); end
    step();
    gold_valid = 1'b0;
    n_checks++; if (pass_count_a !== 32'd1) begin n_fail++; $display("FAIL skip_frozen got %0d exp 1", pass_count_a); end
  endtask

  task automatic test_overflow();
    do_clear();
    do_start(1'b0);
    gold_valid = 1'b0;
    set_lane(0, 2'd0, 16'd1, 64'hA0);
    set_lane(1, 2'd0, 16'd2, 64'hA1);
    step();
    step();
    n_checks++; if ((ovf_b !== 1'b0) || (state_b !== 2'd1)) begin n_fail++; $display("FAIL ovf_full_ok got ovf=%b state=%0d exp ovf=0 state=1", ovf_b, state_b); end
    step();
    clear_lanes();
    n_checks++; if ((ovf_b !== 1'b1) || (state_b !== 2'd3)) begin n_fail++; $display("FAIL ovf_hit got ovf=%b state=%0d exp ovf=1 state=3", ovf_b, state_b); end
    n_checks++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL ovf_deep_ok got %b exp 0", ovf_a); end
    gold_valid = 1'b1;
    gold_entry = mk(1'b0, 2'd0, 16'd1, 64'hA0, 32'd0);
    #1;
    n_checks++; if (gold_ready_b !== 1'b0) begin n_fail++; $display("FAIL ovf_terminal got %b exp 0", gold_ready_b); end
    gold_valid = 1'b0;
    do_clear();
    n_checks++; if ((state_b !== 2'd0) || (ovf_b !== 1'b0) || (err_b !== 1'b0) || (gold_ready_b !== 1'b0)) begin n_fail++; $display("FAIL ovf_clear got state=%0d ovf=%b err=%b ready=%b exp 0", state_b, ovf_b, err_b, gold_ready_b); end
    n_checks++; if ((pass_count_b !== 32'd0) || (err_got_b !== '0) || (err_exp_b !== '0)) begin n_fail++; $display("FAIL ovf_clear_regs got pass=%0d got=%0h exp=%0h exp 0", pass_count_b, err_got_b, err_exp_b); end
  endtask

  task automatic test_pop_frees_slot();
    do_clear();
    do_start(1'b0);
    set_lane(0, 2'd0, 16'd1, 64'hA0);
    set_lane(1, 2'd0, 16'd2, 64'hA1);
    step();
    set_lane(0, 2'd0, 16'd1, 64'hB0);
    set_lane(1, 2'd0, 16'd2, 64'hB1);
    step();
    clear_lanes();
    set_lane(0, 2'd0, 16'd3, 64'hC0);
    gold_valid = 1'b1;
    gold_entry = mk(1'b0, 2'd0, 16'd1, 64'hA0, 32'd0);
    step();
    clear_lanes();
    n_checks++; if ((ovf_b !== 1'b0) || (state_b !== 2'd1) || (pass_count_b !== 32'd1)) begin n_fail++; $display("FAIL slot_freed got ovf=%b state=%0d pass=%0d exp 0/1/1", ovf_b, state_b, pass_count_b); end
    gold_entry = mk(1'b0, 2'd0, 16'd2, 64'hA1, 32'd0); step();
    gold_entry = mk(1'b0, 2'd0, 16'd1, 64'hB0, 32'd0); step();
    gold_entry = mk(1'b0, 2'd0, 16'd2, 64'hB1, 32'd0); step();
    gold_entry = mk(1'b0, 2'd0, 16'd3, 64'hC0, 32'd0); step();
    gold_valid = 1'b0;
    n_checks++; if ((pass_count_b !== 32'd5) || (err_b !== 1'b0)) begin n_fail++; $display("FAIL slot_order got pass=%0d err=%b exp pass=5 err=0", pass_count_b, err_b); end
  endtask

  task automatic test_async_reset();
    do_clear();
    do_start(1'b1);
    set_lane(0, 2'd0, 16'd1, 64'h1);
    set_lane(1, 2'd0, 16'd2, 64'h2);
    step();
    set_lane(0, 2'd0, 16'd3, 64'h3);
    set_lane(1, 2'd0, 16'd4, 64'h4);
    gold_valid = 1'b1;
    gold_entry = mk(1'b0, 2'd0, 16'd1, 64'h1, 32'd0);
    step();
    clear_lanes();
    gold_valid = 1'b0;
    n_checks++; if (pass_count_a !== 32'd1) begin n_fail++; $display("FAIL arst_pre_pass got %0d exp 1", pass_count_a); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if ((state_a !== 2'd0) || (pass_count_a !== 32'd0) || (gold_ready_a !== 1'b0)) begin n_fail++; $display("FAIL arst_immediate got state=%0d pass=%0d ready=%b exp 0", state_a, pass_count_a, gold_ready_a); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    do_start(1'b1);
    set_lane(0, 2'd0, 16'd9, 64'h9);
    step();
    clear_lanes();
    gold_valid = 1'b1;
    gold_entry = mk(1'b0, 2'd0, 16'd9, 64'h9, 32'd0);
    step();
    gold_valid = 1'b0;
    n_checks++; if ((pass_count_a !== 32'd1) || (err_a !== 1'b0)) begin n_fail++; $display("FAIL arst_restart got pass=%0d err=%b exp pass=1 err=0 (stamp 0)", pass_count_a, err_a); end
  endtask

  initial begin
    rst_n      = 1'b0;
    clear      = 1'b0;
    start      = 1'b0;
    check_cyc  = 1'b0;
    gold_valid = 1'b0;
    gold_entry = '0;
    clear_lanes();
    test_reset();
    test_dual_reg();
    test_filter();
    test_cycle_mismatch();
    test_skip();
    test_overflow();
    test_pop_frees_slot();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
